// File: rtl/parking_pkg.sv
// Shared definitions for the parking system: geometry, code width, FSM
// state encodings and the ticket LFSR step. The slot allocator imports
// this package too.
package parking_pkg;

  localparam int SLOT_COUNT = 8;
  localparam int SLOT_W     = 3;
  localparam int CODE_W     = 8;

  // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (shift-left Fibonacci form).
  localparam logic [CODE_W-1:0] LFSR_TAPS = 8'b1011_1000;

  typedef logic [2:0] entry_state_t;
  localparam entry_state_t E_IDLE = 3'd0;
  localparam entry_state_t E_REQ  = 3'd1;
  localparam entry_state_t E_WAIT = 3'd2;
  localparam entry_state_t E_OPEN = 3'd3;
  localparam entry_state_t E_FULL = 3'd4;

  typedef logic [1:0] exit_state_t;
  localparam exit_state_t X_IDLE  = 2'd0;
  localparam exit_state_t X_CHECK = 2'd1;
  localparam exit_state_t X_REL   = 2'd2;
  localparam exit_state_t X_OPEN  = 2'd3;

  // One LFSR step; the top tap keeps the map invertible, so a nonzero
  // state never reaches zero.
  function automatic logic [CODE_W-1:0] lfsr_next(input logic [CODE_W-1:0] s);
    return {s[CODE_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  // Number of occupied slots in a bitmap (0..8).
  function automatic logic [3:0] popcount8(input logic [SLOT_COUNT-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < SLOT_COUNT; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// Request/status port between the gate controller and the slot allocator.
//
// Handshake: car_arrive and car_exit are single-cycle request pulses with no
// ready; the allocator accepts every request on the clock edge where it is
// high. can_park/parking_slot answer the most recent car_arrive and are valid
// from the following edge. exit_from/exit_code qualify car_exit. At most one
// of car_arrive/car_exit is high in any cycle.
interface parking_gate_controller_if;
  import parking_pkg::*;

  logic                  car_arrive;
  logic                  car_exit;
  logic [SLOT_W-1:0]     exit_from;
  logic [CODE_W-1:0]     exit_code;
  logic [SLOT_W-1:0]     parking_slot;
  logic                  can_park;
  logic [SLOT_COUNT-1:0] parking_register;

  modport master (
    output car_arrive, car_exit, exit_from, exit_code,
    input  parking_slot, can_park, parking_register
  );

  modport slave (
    input  car_arrive, car_exit, exit_from, exit_code,
    output parking_slot, can_park, parking_register
  );

endinterface

// File: rtl/parking_gate_timer.sv
// Barrier hold timer: counts cycles while the gate is open (count is zero on
// entry to the open state because it is held at zero while inactive) and
// signals release once the minimum hold has elapsed and the car has left.
module parking_gate_timer #(
  parameter int GATE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic sensor,
  output logic done
);

  localparam logic [4:0] HOLD_MAX = 5'(GATE_CYCLES);

  logic [4:0] count;

  // Saturating open-time counter, cleared whenever the gate is closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!active) begin
      count <= '0;
    end else if (count != HOLD_MAX) begin
      count <= count + 5'd1;
    end
  end

  // Cycle k of the open state sees count == k, so leaving after the cycle
  // with count == HOLD_MAX-1 gives exactly GATE_CYCLES open cycles.
  assign done = active && (count >= HOLD_MAX - 5'd1) && !sensor;

endmodule

// File: rtl/parking_gate_controller.sv
// Gate-side controller: issues LFSR ticket codes at the entry barrier,
// verifies slot/PIN at the exit kiosk, and drives the allocator request port
// with exit requests taking priority over entry requests.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int               GATE_CYCLES = 16,
  parameter logic [CODE_W-1:0] LFSR_SEED  = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       entry_sensor,
  input  logic                       exit_sensor,
  input  logic                       exit_req,
  input  logic [SLOT_W-1:0]          exit_slot,
  input  logic [CODE_W-1:0]          exit_pin,
  parking_gate_controller_if.master  alloc,
  output logic                       entry_gate_open,
  output logic                       exit_gate_open,
  output logic                       lot_full,
  output logic                       ticket_valid,
  output logic [SLOT_W-1:0]          ticket_slot,
  output logic [CODE_W-1:0]          ticket_code,
  output logic                       exit_denied,
  output logic [3:0]                 occupancy,
  output entry_state_t               entry_state,
  output exit_state_t                exit_state
);

  logic [CODE_W-1:0] lfsr;
  entry_state_t      e_next;
  exit_state_t       x_next;
  logic [CODE_W-1:0] code_table [SLOT_COUNT];
  logic [SLOT_COUNT-1:0] ticket_ok;
  logic [SLOT_W-1:0] x_slot;
  logic [CODE_W-1:0] x_pin;
  logic              check_pass;
  logic              grant;
  logic              entry_done;
  logic              exit_done;

  // Exit owns the allocator port in X_REL; an entry request waits in E_REQ.
  assign alloc.car_exit   = (exit_state == X_REL);
  assign alloc.car_arrive = (entry_state == E_REQ) && (exit_state != X_REL);

  assign grant      = (entry_state == E_WAIT) && alloc.can_park;
  assign check_pass = ticket_ok[x_slot] && alloc.parking_register[x_slot] &&
                      (code_table[x_slot] == x_pin);

  assign entry_gate_open = (entry_state == E_OPEN);
  assign exit_gate_open  = (exit_state == X_OPEN);
  assign lot_full        = (entry_state == E_FULL);

  parking_gate_timer #(.GATE_CYCLES(GATE_CYCLES)) u_entry_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (entry_gate_open),
    .sensor (entry_sensor),
    .done   (entry_done)
  );

  parking_gate_timer #(.GATE_CYCLES(GATE_CYCLES)) u_exit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (exit_gate_open),
    .sensor (exit_sensor),
    .done   (exit_done)
  );

  // Free-running ticket code generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_next(lfsr);
  end

  // Entry FSM next state.
  always_comb begin
    e_next = entry_state;
    case (entry_state)
      E_IDLE: if (entry_sensor) e_next = (alloc.parking_register == '1) ? E_FULL : E_REQ;
      E_REQ:  if (alloc.car_arrive) e_next = E_WAIT;
      E_WAIT: e_next = alloc.can_park ? E_OPEN : E_FULL;
      E_OPEN: if (entry_done) e_next = E_IDLE;
      E_FULL: if (!entry_sensor) e_next = E_IDLE;
      default: e_next = E_IDLE;
    endcase
  end

  // Exit FSM next state.
  always_comb begin
    x_next = exit_state;
    case (exit_state)
      X_IDLE:  if (exit_req) x_next = X_CHECK;
      X_CHECK: x_next = check_pass ? X_REL : X_IDLE;
      X_REL:   x_next = X_OPEN;
      X_OPEN:  if (exit_done) x_next = X_IDLE;
      default: x_next = X_IDLE;
    endcase
  end

  // State registers plus registered status pulses and kiosk capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_state     <= E_IDLE;
      exit_state      <= X_IDLE;
      ticket_valid    <= 1'b0;
      ticket_slot     <= '0;
      ticket_code     <= '0;
      exit_denied     <= 1'b0;
      x_slot          <= '0;
      x_pin           <= '0;
      alloc.exit_from <= '0;
      alloc.exit_code <= '0;
      occupancy       <= '0;
    end else begin
      entry_state  <= e_next;
      exit_state   <= x_next;
      ticket_valid <= grant;
      if (grant) begin
        ticket_slot <= alloc.parking_slot;
        ticket_code <= lfsr;
      end
      exit_denied <= (exit_state == X_CHECK) && !check_pass;
      if (exit_state == X_IDLE && exit_req) begin
        x_slot <= exit_slot;
        x_pin  <= exit_pin;
      end
      // Release fields load once and then hold while car_exit is low.
      if (exit_state == X_CHECK && check_pass) begin
        alloc.exit_from <= x_slot;
        alloc.exit_code <= x_pin;
      end
      occupancy <= popcount8(alloc.parking_register);
    end
  end

  // Ticket table: written on grant, invalidated on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ticket_ok <= '0;
      for (int i = 0; i < SLOT_COUNT; i++) code_table[i] <= '0;
    end else begin
      if (exit_state == X_REL) ticket_ok[x_slot] <= 1'b0;
      if (grant) begin
        ticket_ok[alloc.parking_slot]  <= 1'b1;
        code_table[alloc.parking_slot] <= lfsr;
      end
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: scenario tasks drive the gate sensors,
// kiosk and allocator status; tickets and releases are scoreboarded.
module tb_parking_gate_controller;
  import parking_pkg::*;

  localparam int GATE_CYCLES = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              entry_sensor = 1'b0;
  logic              exit_sensor  = 1'b0;
  logic              exit_req     = 1'b0;
  logic [2:0]        exit_slot    = '0;
  logic [7:0]        exit_pin     = '0;
  logic              entry_gate_open, exit_gate_open, lot_full, ticket_valid, exit_denied;
  logic [2:0]        ticket_slot;
  logic [7:0]        ticket_code;
  logic [3:0]        occupancy;
  entry_state_t      entry_state;
  exit_state_t       exit_state;

  parking_gate_controller_if alloc_if();

  parking_gate_controller #(.GATE_CYCLES(GATE_CYCLES), .LFSR_SEED(8'hA5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .entry_sensor    (entry_sensor),
    .exit_sensor     (exit_sensor),
    .exit_req        (exit_req),
    .exit_slot       (exit_slot),
    .exit_pin        (exit_pin),
    .alloc           (alloc_if),
    .entry_gate_open (entry_gate_open),
    .exit_gate_open  (exit_gate_open),
    .lot_full        (lot_full),
    .ticket_valid    (ticket_valid),
    .ticket_slot     (ticket_slot),
    .ticket_code     (ticket_code),
    .exit_denied     (exit_denied),
    .occupancy       (occupancy),
    .entry_state     (entry_state),
    .exit_state      (exit_state)
  );

  // ---------------- bench state ----------------
  int n_vec = 0;
  int n_err = 0;
  int arrive_cnt = 0;
  int exit_cnt = 0;
  logic [10:0] exp_ticket_q[$];
  logic [10:0] exp_rel_q[$];
  logic [7:0]  ticket_m [8];
  logic [7:0]  occ_bits;
  logic [7:0]  lfsr_m;

  // Reference ticket generator: x^8+x^6+x^5+x^4+1, seed 8'hA5.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  function automatic logic [32:0] outs();
    return {alloc_if.car_arrive, alloc_if.car_exit, alloc_if.exit_from, alloc_if.exit_code,
            entry_gate_open, exit_gate_open, lot_full, ticket_valid, ticket_slot,
            ticket_code, exit_denied, occupancy};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (alloc_if.car_arrive) arrive_cnt++;
      if (alloc_if.car_exit)   exit_cnt++;
      if (alloc_if.car_arrive || alloc_if.car_exit) begin
        n_vec++;
        if (alloc_if.car_arrive && alloc_if.car_exit) begin
          n_err++;
          $display("FAIL port_overlap: car_arrive=1 car_exit=1, required at most one high");
        end
      end
      if (ticket_valid) begin
        n_vec++;
        if (exp_ticket_q.size() == 0) begin
          n_err++;
          $display("FAIL ticket_unexpected: slot=%0d code=%h, required no ticket", ticket_slot, ticket_code);
        end else begin
          logic [10:0] e;
          e = exp_ticket_q.pop_front();
          if ({ticket_slot, ticket_code} !== e) begin
            n_err++;
            $display("FAIL ticket_content: slot=%0d code=%h, required slot=%0d code=%h",
                     ticket_slot, ticket_code, e[10:8], e[7:0]);
          end
        end
      end
      if (alloc_if.car_exit) begin
        n_vec++;
        if (exp_rel_q.size() == 0) begin
          n_err++;
          $display("FAIL release_unexpected: exit_from=%0d exit_code=%h, required no car_exit",
                   alloc_if.exit_from, alloc_if.exit_code);
        end else begin
          logic [10:0] e;
          e = exp_rel_q.pop_front();
          if ({alloc_if.exit_from, alloc_if.exit_code} !== e) begin
            n_err++;
            $display("FAIL release_content: exit_from=%0d exit_code=%h, required %0d/%h",
                     alloc_if.exit_from, alloc_if.exit_code, e[10:8], e[7:0]);
          end
        end
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    occ_bits = 8'h00;
    alloc_if.can_park = 1'b0;
    alloc_if.parking_slot = 3'd0;
    alloc_if.parking_register = occ_bits;
    repeat (3) @(negedge clk);
    n_vec++;
    if (outs() !== 33'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, required 0", outs());
    end
    n_vec++;
    if ({entry_state, exit_state} !== {E_IDLE, X_IDLE}) begin
      n_err++;
      $display("FAIL reset_state: entry=%0d exit=%0d, required idle", entry_state, exit_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (outs() !== 33'd0) begin
      n_err++;
      $display("FAIL idle_outputs: got %h, required 0", outs());
    end
  endtask

  task automatic test_entry(input logic [2:0] slot, input bit early);
    int lat;
    int open;
    int a0;
    a0 = arrive_cnt;
    alloc_if.can_park = 1'b1;
    alloc_if.parking_slot = slot;
    entry_sensor = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!alloc_if.car_arrive && lat < 10);
    n_vec++;
    if (lat !== 1) begin
      n_err++;
      $display("FAIL entry_arrive_latency: %0d cycles, required 1", lat);
    end
    @(negedge clk);
    exp_ticket_q.push_back({slot, lfsr_m});
    ticket_m[slot] = lfsr_m;
    lat = 1;
    do begin @(negedge clk); lat++; end while (!ticket_valid && lat < 10);
    n_vec++;
    if (lat !== 2 || entry_gate_open !== 1'b1) begin
      n_err++;
      $display("FAIL entry_ticket_gate: latency=%0d gate=%b, required 2 and 1", lat, entry_gate_open);
    end
    if (early) entry_sensor = 1'b0;
    open = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!entry_gate_open) break;
      open++;
      if (!early && open == 24) entry_sensor = 1'b0;
    end
    n_vec++;
    if (open !== (early ? GATE_CYCLES : 24)) begin
      n_err++;
      $display("FAIL entry_gate_hold: open %0d cycles, required %0d", open, early ? GATE_CYCLES : 24);
    end
    n_vec++;
    if (arrive_cnt - a0 !== 1) begin
      n_err++;
      $display("FAIL entry_arrive_pulses: %0d, required 1", arrive_cnt - a0);
    end
    occ_bits[slot] = 1'b1;
    alloc_if.parking_register = occ_bits;
    alloc_if.can_park = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (occupancy !== 4'($countones(occ_bits))) begin
      n_err++;
      $display("FAIL occupancy: %0d, required %0d", occupancy, $countones(occ_bits));
    end
  endtask

  task automatic test_lot_full();
    int a0;
    a0 = arrive_cnt;
    alloc_if.parking_register = 8'hFF;
    entry_sensor = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (lot_full !== 1'b1) begin
      n_err++;
      $display("FAIL lot_full_set: lot_full=%b, required 1", lot_full);
    end
    repeat (8) @(negedge clk);
    n_vec++;
    if (lot_full !== 1'b1 || entry_gate_open !== 1'b0) begin
      n_err++;
      $display("FAIL lot_full_hold: lot_full=%b gate=%b, required 1 and 0", lot_full, entry_gate_open);
    end
    entry_sensor = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (lot_full !== 1'b0 || arrive_cnt !== a0) begin
      n_err++;
      $display("FAIL lot_full_clear: lot_full=%b arrivals=%0d, required 0 and 0", lot_full, arrive_cnt - a0);
    end
    // Allocator refuses a request although the bitmap is not full.
    alloc_if.parking_register = occ_bits;
    alloc_if.can_park = 1'b0;
    entry_sensor = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (lot_full !== 1'b1 || entry_gate_open !== 1'b0 || arrive_cnt - a0 !== 1) begin
      n_err++;
      $display("FAIL no_grant_full: lot_full=%b gate=%b arrivals=%0d, required 1 0 1",
               lot_full, entry_gate_open, arrive_cnt - a0);
    end
    entry_sensor = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_exit_denied(input logic [2:0] slot, input logic [7:0] pin);
    int lat;
    int e0;
    bit opened;
    e0 = exit_cnt;
    opened = 1'b0;
    exit_slot = slot;
    exit_pin = pin;
    exit_req = 1'b1;
    @(negedge clk);
    exit_req = 1'b0;
    lat = 1;
    do begin @(negedge clk); lat++; end while (!exit_denied && lat < 10);
    n_vec++;
    if (lat !== 2) begin
      n_err++;
      $display("FAIL exit_denied_latency: %0d cycles, required 2", lat);
    end
    @(negedge clk);
    n_vec++;
    if (exit_denied !== 1'b0) begin
      n_err++;
      $display("FAIL exit_denied_pulse: still %b one cycle later, required 0", exit_denied);
    end
    repeat (GATE_CYCLES) begin
      @(negedge clk);
      if (exit_gate_open) opened = 1'b1;
    end
    n_vec++;
    if (opened !== 1'b0 || exit_cnt !== e0) begin
      n_err++;
      $display("FAIL exit_denied_no_release: gate_opened=%b releases=%0d, required 0 and 0",
               opened, exit_cnt - e0);
    end
  endtask

  task automatic test_exit_ok(input logic [2:0] slot);
    int lat;
    int open;
    int e0;
    bit den;
    e0 = exit_cnt;
    exp_rel_q.push_back({slot, ticket_m[slot]});
    exit_sensor = 1'b1;
    exit_slot = slot;
    exit_pin = ticket_m[slot];
    exit_req = 1'b1;
    @(negedge clk);
    exit_req = 1'b0;
    lat = 1;
    do begin @(negedge clk); lat++; end while (!alloc_if.car_exit && lat < 10);
    n_vec++;
    if (lat !== 2) begin
      n_err++;
      $display("FAIL exit_release_latency: %0d cycles, required 2", lat);
    end
    @(negedge clk);
    n_vec++;
    if (exit_gate_open !== 1'b1) begin
      n_err++;
      $display("FAIL exit_gate_after_release: gate=%b, required 1", exit_gate_open);
    end
    exit_sensor = 1'b0;
    open = 1;
    den = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exit_req = 1'b0;
      if (exit_denied) den = 1'b1;
      if (!exit_gate_open) break;
      open++;
      if (open == 3) begin
        exit_slot = slot;
        exit_pin = ~ticket_m[slot];
        exit_req = 1'b1;
      end
    end
    n_vec++;
    if (open !== GATE_CYCLES || den !== 1'b0) begin
      n_err++;
      $display("FAIL exit_gate_hold: open %0d cycles denied=%b, required %0d and 0", open, den, GATE_CYCLES);
    end
    n_vec++;
    if ({alloc_if.car_exit, alloc_if.exit_from, alloc_if.exit_code} !== {1'b0, slot, ticket_m[slot]} ||
        exit_cnt - e0 !== 1) begin
      n_err++;
      $display("FAIL exit_fields_hold: car_exit=%b from=%0d code=%h pulses=%0d, required 0 %0d %h 1",
               alloc_if.car_exit, alloc_if.exit_from, alloc_if.exit_code, exit_cnt - e0, slot, ticket_m[slot]);
    end
    occ_bits[slot] = 1'b0;
    alloc_if.parking_register = occ_bits;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit closed;
    exp_rel_q.push_back({3'd3, ticket_m[3]});
    exit_slot = 3'd3;
    exit_pin = ticket_m[3];
    exit_sensor = 1'b1;
    exit_req = 1'b1;
    @(negedge clk);
    exit_req = 1'b0;
    alloc_if.can_park = 1'b1;
    alloc_if.parking_slot = 3'd4;
    entry_sensor = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({alloc_if.car_exit, alloc_if.car_arrive} !== 2'b10) begin
      n_err++;
      $display("FAIL arb_exit_first: car_exit=%b car_arrive=%b, required 1 0",
               alloc_if.car_exit, alloc_if.car_arrive);
    end
    @(negedge clk);
    n_vec++;
    if ({alloc_if.car_exit, alloc_if.car_arrive} !== 2'b01) begin
      n_err++;
      $display("FAIL arb_entry_next: car_exit=%b car_arrive=%b, required 0 1",
               alloc_if.car_exit, alloc_if.car_arrive);
    end
    @(negedge clk);
    exp_ticket_q.push_back({3'd4, lfsr_m});
    ticket_m[4] = lfsr_m;
    @(negedge clk);
    n_vec++;
    if ({ticket_valid, entry_gate_open, exit_gate_open} !== 3'b111) begin
      n_err++;
      $display("FAIL arb_both_gates: ticket=%b entry=%b exit=%b, required 1 1 1",
               ticket_valid, entry_gate_open, exit_gate_open);
    end
    entry_sensor = 1'b0;
    exit_sensor = 1'b0;
    alloc_if.can_park = 1'b0;
    closed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!entry_gate_open && !exit_gate_open) begin closed = 1'b1; break; end
    end
    n_vec++;
    if (closed !== 1'b1) begin
      n_err++;
      $display("FAIL arb_gates_close: entry=%b exit=%b after 40 cycles, required 0 0",
               entry_gate_open, exit_gate_open);
    end
    occ_bits[3] = 1'b0;
    occ_bits[4] = 1'b1;
    alloc_if.parking_register = occ_bits;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    test_entry(3'd5, 1'b1);
    exp_rel_q.push_back({3'd5, ticket_m[5]});
    exit_sensor = 1'b1;
    exit_slot = 3'd5;
    exit_pin = ticket_m[5];
    exit_req = 1'b1;
    @(negedge clk);
    exit_req = 1'b0;
    lat = 1;
    do begin @(negedge clk); lat++; end while (!exit_gate_open && lat < 10);
    n_vec++;
    if (exit_gate_open !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_gate_open: gate=%b after %0d cycles, required 1", exit_gate_open, lat);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (outs() !== 33'd0 || {entry_state, exit_state} !== {E_IDLE, X_IDLE}) begin
      n_err++;
      $display("FAIL async_reset_outputs: outs=%h entry=%0d exit=%0d, required all 0",
               outs(), entry_state, exit_state);
    end
    @(negedge clk);
    exit_sensor = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // Allocator still shows slot 5 occupied; only the cleared table can refuse.
    test_exit_denied(3'd5, ticket_m[5]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    test_reset();
    test_entry(3'd0, 1'b1);
    test_entry(3'd2, 1'b0);
    test_lot_full();
    test_exit_denied(3'd2, ticket_m[2] ^ 8'h01);
    test_exit_ok(3'd2);
    test_exit_denied(3'd2, ticket_m[2]);
    test_entry(3'd3, 1'b1);
    test_back_to_back();
    test_reset_mid();
    n_vec++;
    if (exp_ticket_q.size() != 0 || exp_rel_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d tickets and %0d releases outstanding, required 0",
               exp_ticket_q.size(), exp_rel_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
